// File: rtl/stage_pkg.sv
// ============================================================================
// Module   : stage_pkg
// Brief    : Shared lane/index constants, FIFO entry type and lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_pkg;

    localparam int PARALLEL_SIZE = 12;
    localparam int PARA          = 16;
    localparam int LANE_W        = $clog2(PARALLEL_SIZE);

    typedef struct packed {
        logic              last;
        logic [LANE_W-1:0] lane;
        logic [PARA-1:0]   idx;
    } oob_entry_t;

    localparam int ENTRY_W = $bits(oob_entry_t);

    // Scanning downward leaves the lowest set lane as the final assignment.
    function automatic logic [LANE_W-1:0] lowest_set(input logic [PARALLEL_SIZE-1:0] v);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int i = PARALLEL_SIZE - 1; i >= 0; i--) begin
            if (v[i]) r = LANE_W'(i);
        end
        return r;
    endfunction

    function automatic logic is_one_hot(input logic [PARALLEL_SIZE-1:0] v);
        return (v != '0) && ((v & (v - PARALLEL_SIZE'(1))) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/oob_index_collector_if.sv
// ============================================================================
// Module   : oob_index_collector_if
// Brief    : Result-vector input and index-stream output handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oob_index_collector_if;
    import stage_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [PARALLEL_SIZE-1:0]      in_flag;
    logic [PARALLEL_SIZE*PARA-1:0] in_idx;

    logic                          out_valid;
    logic                          out_ready;
    logic [PARA-1:0]               out_idx;
    logic [LANE_W-1:0]             out_lane;
    logic                          out_last;

    modport master (
        output in_valid, in_flag, in_idx, out_ready,
        input  in_ready, out_valid, out_idx, out_lane, out_last
    );

    modport slave (
        input  in_valid, in_flag, in_idx, out_ready,
        output in_ready, out_valid, out_idx, out_lane, out_last
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Registered show-ahead FIFO, power-of-two depth, no push-to-pop bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/oob_index_collector.sv
// ============================================================================
// Module   : oob_index_collector
// Brief    : Snapshots flagged lanes and streams them lowest-lane-first via a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oob_index_collector
    import stage_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    oob_index_collector_if.slave      bus,
    output logic      [PARA-1:0]      entry_cnt
);

    logic [PARALLEL_SIZE-1:0]      r_pending;
    logic [PARALLEL_SIZE*PARA-1:0] r_snap_idx;
    logic [PARA-1:0]               r_entry_cnt;

    logic [LANE_W-1:0]             w_lane;
    oob_entry_t                    w_push_entry;
    oob_entry_t                    w_head;
    oob_entry_t                    w_head_out;
    logic                          w_full;
    logic                          w_empty;
    logic [$clog2(DEPTH):0]        w_count;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_in_ready;
    logic                          w_accept;

    assign w_lane = lowest_set(r_pending);
    assign w_pop  = (w_count != '0) && bus.out_ready;
    assign w_push = (r_pending != '0) && (!w_full || w_pop);
    // Draining the final pending lane frees the snapshot regs for the next vector.
    assign w_in_ready = (r_pending == '0) || (is_one_hot(r_pending) && w_push);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.last = is_one_hot(r_pending);
        w_push_entry.lane = w_lane;
        w_push_entry.idx  = r_snap_idx[w_lane*PARA +: PARA];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_snap_idx  <= '0;
            r_entry_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_pending  <= bus.in_flag;
                r_snap_idx <= bus.in_idx;
            end else if (w_push) begin
                r_pending <= r_pending & ~(PARALLEL_SIZE'(1) << w_lane);
            end
            if (w_pop) r_entry_cnt <= r_entry_cnt + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Unwritten storage must not leak onto the head fields while empty.
    assign w_head_out    = w_empty ? '0 : w_head;
    assign bus.out_valid = (w_count != '0);
    assign bus.out_idx   = w_head_out.idx;
    assign bus.out_lane  = w_head_out.lane;
    assign bus.out_last  = w_head_out.last;
    assign bus.in_ready  = w_in_ready;
    assign entry_cnt     = r_entry_cnt;

endmodule

`default_nettype wire
